edge_propagator_rx: RTL and testbench
=====================================

Name: edge_propagator_rx

Overview:
- Receiving end of the two-wire edge-propagation handshake. The transmitter holds a level request `valid_i` until it sees the acknowledge (in its own domain), then drops the request.
- This block runs in the destination clock domain. It synchronises the asynchronous request and presents it as a single event on a valid/ready interface.
- `ack_o` is raised only after the consumer accepts the event, so the source is back-pressured.
- Adds an event counter and a busy flag for status and debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `valid_i`; legal range 2..4.
- CNT_W, 8, width of the accepted-event counter.

Ports:
- clk_i  input  1  destination-domain clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  request level from the transmitter, asynchronous to `clk_i`.
- ack_o  output  1  acknowledge level returned to the transmitter; registered, glitch-free.
- valid_o  output  1  event pending towards the consumer.
- ready_i  input  1  consumer ready; the event transfers on a cycle with `valid_o & ready_i`.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- clr_cnt_i  input  1  synchronous clear of `event_cnt_o`.
- event_cnt_o  output  CNT_W  number of accepted events, modulo 2^CNT_W.

Behaviour:
- Reset values: sync chain all 0; state IDLE; `ack_o`=0; `valid_o`=0; `busy_o`=0; `event_cnt_o`=0.
- Synchroniser:
  - `valid_i` feeds a SYNC_STAGES-deep flop chain; `req_s` is the last stage.
  - No logic is placed before stage 0.
  - If `valid_i` rises before edge k, `req_s` is high after edge k+SYNC_STAGES-1.
- FSM states: IDLE, PEND, ACK.
  - IDLE: `ack_o`=0, `valid_o`=0. When `req_s`=1 at an edge, go to PEND.
  - PEND: `valid_o`=1 (decoded from state), `ack_o`=0. On an edge with `ready_i`=1, go to ACK, set `ack_o`=1 and increment the counter. Otherwise stay in PEND.
  - ACK: `ack_o`=1, `valid_o`=0. When `req_s`=0 at an edge, go to IDLE and clear `ack_o`.
- Ordering rules:
  - Exactly one event per request rising level; no event is ever duplicated.
  - If `valid_i` drops while in PEND (protocol violation), the event is still delivered and `ack_o` is still raised. ACK then exits on the next edge where `req_s`=0.
- Latency (`ready_i` held high):
  - `valid_i` rise to `valid_o` high: SYNC_STAGES+1 edges.
  - `valid_o` high to `ack_o` high: 1 edge (the accept edge).
  - `req_s` low to `ack_o` low: 1 edge.
- Back-to-back: IDLE re-entered with `req_s` already 1 (a new request synchronised) goes to PEND on the next edge; no request is lost.
- `busy_o` is 1 in PEND and ACK.
- Counter:
  - Increments by 1 on each accept; wraps from 2^CNT_W-1 to 0 without a flag.
  - `clr_cnt_i` forces 0 on the next edge.
  - Simultaneous clear and accept yields 0 (clear has priority).
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - Any PEND event is discarded and `ack_o` drops.
  - If the transmitter still holds `valid_i`=1 after reset release, the request is re-synchronised and delivered as a new event. The source and destination domains must be reset together to avoid this.
- Parameter checks: SYNC_STAGES<2 or CNT_W<1 is an elaboration error.

Test Plan:
- Single event, `ready_i`=1, SYNC_STAGES=2:
  - Raise `valid_i` → `valid_o` high for exactly 1 cycle, 3 edges after the rise; `ack_o` high on the next edge.
  - Drop `valid_i` → `ack_o` low 3 edges later; `event_cnt_o`=1; `busy_o` back to 0.
- Backpressure: hold `ready_i`=0 for 10 cycles after `valid_o` rises → `valid_o` stays high and `ack_o` stays 0. Release `ready_i` → accept, `ack_o`=1, count +1.
- Pairing with the transmitter (cross-domain, ratios 1:3 and 3:1), 100 single-cycle source pulses spaced ≥ one full handshake apart → exactly 100 accepts, `event_cnt_o`=100; no `valid_o` while in ACK.
- Counter wrap and clear:
  - CNT_W=2, 5 events → `event_cnt_o`=1.
  - Assert `clr_cnt_i` on an accept edge → `event_cnt_o`=0.
- Reset in PEND with `valid_i` held at 1 → `valid_o`/`ack_o`/`busy_o` go 0 asynchronously. After release, a new event appears SYNC_STAGES+1 edges later.
- Protocol violation: `valid_i` pulsed for 1 source cycle only (shorter than the sync window, but sampled once) → one event delivered; `ack_o` pulses for 1 cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/edge_propagator_rx.sv
// Destination-domain receiver of the two-wire edge-propagation handshake.
// Synchronises the request level and presents exactly one valid/ready event per rising request.
module edge_propagator_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ack_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] event_cnt_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_propagator_rx: SYNC_STAGES must be in 2..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("edge_propagator_rx: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_s;
  logic                   accept;

  // Stage 0 samples valid_i directly; nothing may sit in front of the first flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], valid_i};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          state_d = PEND;
        end
      end
      PEND: begin
        // A request that vanished while pending is still delivered and acknowledged.
        if (ready_i) begin
          state_d = ACK;
          ack_d   = 1'b1;
          accept  = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr_cnt_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o       = ack_q;
  assign valid_o     = (state_q == PEND);
  assign busy_o      = (state_q != IDLE);
  assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_edge_propagator_rx.sv
// Self-checking bench for edge_propagator_rx: directed timing pins plus randomized
// cross-domain transmitter traffic compared every cycle against an event-level model.
module tb_edge_propagator_rx;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rstn;
  logic             valid_i;
  logic             ack_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             clr_cnt_i;
  logic [CNT_W-1:0] event_cnt_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit tx_done;

  // Model state: request samples in flight, one outstanding event, acknowledge level, count.
  bit   hist[$];
  bit   m_pend = 1'b0;
  bit   m_ack  = 1'b0;
  int   m_cnt  = 0;

  edge_propagator_rx #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .valid_i    (valid_i),
    .ack_o      (ack_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .clr_cnt_i  (clr_cnt_i),
    .event_cnt_o(event_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #6 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit req;
    bit acc;
    if (!rstn) begin
      hist.delete();
      for (int i = 0; i < int'(SYNC); i++) hist.push_back(1'b0);
      m_pend = 1'b0;
      m_ack  = 1'b0;
      m_cnt  = 0;
      return;
    end
    req = hist.pop_front();
    hist.push_back(valid_i);
    acc = 1'b0;
    if (m_pend) begin
      if (ready_i) begin
        m_pend = 1'b0;
        m_ack  = 1'b1;
        acc    = 1'b1;
      end
    end else if (m_ack) begin
      if (!req) m_ack = 1'b0;
    end else if (req) begin
      m_pend = 1'b1;
    end
    if (clr_cnt_i) m_cnt = 0;
    else if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("valid_o", valid_o, m_pend);
      chk("ack_o", ack_o, m_ack);
      chk("busy_o", busy_o, m_pend | m_ack);
      chk("event_cnt_o", event_cnt_o, m_cnt);
      chk("valid_during_ack", valid_o & ack_o, 0);
    end
  end

  // sel: 0 valid_o, 1 ack_o, 2 busy_o
  task automatic wait_cond(input string nm, input int sel, input logic val);
    logic cur;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      case (sel)
        0:       cur = valid_o;
        1:       cur = ack_o;
        default: cur = busy_o;
      endcase
      if (cur === val) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s: actual=timeout required=%0d at t=%0t", nm, val, $time);
  endtask

  task automatic one_event();
    @(negedge clk);
    valid_i = 1'b1;
    wait_cond("ack_high", 1, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    wait_cond("idle", 2, 1'b0);
  endtask

  // Transmitter in its own clock domain: hold request until the two-flop synchronised ack is seen.
  task automatic run_tx(input int n, input int p);
    logic s1, s2;
    int   t;
    @(negedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      valid_i = 1'b1;
      s1 = 1'b0; s2 = 1'b0; t = 0;
      while (!s2 && t < 400) begin
        #(p);
        s2 = s1; s1 = ack_o; t++;
      end
      if (!s2) begin
        checks++; errors++;
        $display("FAIL timeout_tx_ack: actual=timeout required=1 at t=%0t", $time);
      end
      valid_i = 1'b0;
      s1 = 1'b1; s2 = 1'b1; t = 0;
      while (s2 && t < 400) begin
        #(p);
        s2 = s1; s1 = ack_o; t++;
      end
      if (s2) begin
        checks++; errors++;
        $display("FAIL timeout_tx_release: actual=timeout required=0 at t=%0t", $time);
      end
      #(p * int'($urandom_range(0, 3)));
    end
  endtask

  task automatic random_phase(input int p);
    @(negedge clk);
    clr_cnt_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b0;
    tx_done = 1'b0;
    fork
      begin
        run_tx(100, p);
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(negedge clk);
          ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    ready_i = 1'b1;
    wait_cond("tx_idle", 2, 1'b0);
    chk("tx_count", event_cnt_o, 100);
  endtask

  initial begin
    rstn = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_ack_o", ack_o, 0);
    chk("reset_busy_o", busy_o, 0);
    chk("reset_cnt", event_cnt_o, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single event: valid_o on 3rd edge for one cycle, ack_o from 4th edge.
    valid_i = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      chk($sformatf("single_valid_e%0d", e), valid_o, (e == 3));
      chk($sformatf("single_ack_e%0d", e), ack_o, (e >= 4));
    end
    @(negedge clk);
    valid_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      chk($sformatf("release_ack_e%0d", e), ack_o, (e < 3));
    end
    chk("single_busy", busy_o, 0);
    chk("single_cnt", event_cnt_o, 1);

    // Backpressure: ten stalled cycles, then accept.
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    wait_cond("bp_valid", 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", valid_o, 1);
      chk("bp_hold_ack", ack_o, 0);
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_accept_ack", ack_o, 1);
    chk("bp_accept_valid", valid_o, 0);
    chk("bp_cnt", event_cnt_o, 2);
    @(negedge clk);
    valid_i = 1'b0;
    wait_cond("bp_idle", 2, 1'b0);

    // Request held for a single destination cycle still yields one event and a 1-cycle ack.
    @(negedge clk);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    for (int e = 2; e <= 6; e++) begin
      @(posedge clk); #1;
      chk($sformatf("short_valid_e%0d", e), valid_o, (e == 3));
      chk($sformatf("short_ack_e%0d", e), ack_o, (e == 4));
    end
    chk("short_busy", busy_o, 0);
    chk("short_cnt", event_cnt_o, 3);

    // Asynchronous reset while pending, request still held: re-delivered afterwards.
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    wait_cond("rst_valid", 0, 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_valid", valid_o, 0);
    chk("rst_async_ack", ack_o, 0);
    chk("rst_async_busy", busy_o, 0);
    chk("rst_async_cnt", event_cnt_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_redeliver_e%0d", e), valid_o, (e == 3));
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_accept_ack", ack_o, 1);
    chk("rst_cnt", event_cnt_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    wait_cond("rst_idle", 2, 1'b0);

    // Clear coinciding with an accept wins.
    @(negedge clk);
    ready_i = 1'b0;
    valid_i = 1'b1;
    wait_cond("clr_valid", 0, 1'b1);
    @(negedge clk);
    ready_i = 1'b1;
    clr_cnt_i = 1'b1;
    @(posedge clk); #1;
    chk("clr_accept_ack", ack_o, 1);
    chk("clr_accept_cnt", event_cnt_o, 0);
    @(negedge clk);
    clr_cnt_i = 1'b0;
    valid_i = 1'b0;
    wait_cond("clr_idle", 2, 1'b0);

    // Wrap: 257 events from zero land on 1.
    for (int k = 0; k < 257; k++) one_event();
    chk("wrap_cnt", event_cnt_o, 1);

    // Cross-domain transmitter: slow source (3x dest period), then fast source.
    random_phase(36);
    random_phase(4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
